// File: rtl/p3_pkg.sv
// ============================================================================
//  Module   : p3_pkg
//  Brief    : Shared constants, command codes and parser state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package p3_pkg;

   localparam logic [7:0] SOF       = 8'hFE;
   localparam logic [7:0] EOF       = 8'hEF;

   localparam logic [7:0] CMD_SIZE  = 8'h01;
   localparam logic [7:0] CMD_START = 8'h03;
   localparam logic [7:0] CMD_LOAD  = 8'h04;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LEN     = 3'd1,
      ST_CMD     = 3'd2,
      ST_PAYLOAD = 3'd3,
      ST_EOFCHK  = 3'd4
   } parser_state_t;

endpackage

`default_nettype wire

// File: rtl/timeout_counter.sv
// ============================================================================
//  Module   : timeout_counter
//  Brief    : Idle-cycle counter that saturates at LIMIT and flags it.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timeout_counter #(
   parameter int LIMIT = 20000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_limit
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] r_count;
   logic          w_at_limit;

   assign w_at_limit = (r_count == CW'(LIMIT));
   assign o_limit    = w_at_limit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !w_at_limit) begin
         r_count <= r_count + CW'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_frame_parser.sv
// ============================================================================
//  Module   : uart_frame_parser
//  Brief    : Validates FE <len> <cmd> <payload..> EF frames from the UART RX.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_frame_parser
   import p3_pkg::*;
#(
   parameter int WORD_LENGTH    = 8,
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WORD_LENGTH-1:0] rx_data,
   input  logic                   rx_valid,
   input  logic                   rx_err,
   output logic [WORD_LENGTH-1:0] cmd,
   output logic                   cmd_valid,
   output logic [WORD_LENGTH-1:0] payload_data,
   output logic                   payload_valid,
   output logic [WORD_LENGTH-1:0] payload_index,
   output logic                   frame_done,
   output logic                   frame_err
);

   parser_state_t          r_state, w_state;
   logic [WORD_LENGTH-1:0] r_len, w_len;
   logic [WORD_LENGTH-1:0] r_pcnt, w_pcnt;
   logic [WORD_LENGTH-1:0] r_cmd, w_cmd;
   logic [WORD_LENGTH-1:0] r_pdata, w_pdata;
   logic [WORD_LENGTH-1:0] r_pidx, w_pidx;
   logic                   r_cmd_valid, w_cmd_valid;
   logic                   r_pvalid, w_pvalid;
   logic                   r_done, w_done;
   logic                   r_err, w_err;
   logic                   w_timeout;
   logic                   w_in_frame;
   logic                   w_last_payload;

   assign w_in_frame     = (r_state != ST_IDLE);
   assign w_last_payload = ((r_pcnt + WORD_LENGTH'(1)) == (r_len - WORD_LENGTH'(2)));

   // Counter is held at zero while idle so every frame starts with a fresh budget.
   timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .rst_n    (reset),
      .i_clear  (rx_valid || !w_in_frame),
      .i_enable (w_in_frame),
      .o_limit  (w_timeout)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_len       <= '0;
         r_pcnt      <= '0;
         r_cmd       <= '0;
         r_pdata     <= '0;
         r_pidx      <= '0;
         r_cmd_valid <= 1'b0;
         r_pvalid    <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_len       <= w_len;
         r_pcnt      <= w_pcnt;
         r_cmd       <= w_cmd;
         r_pdata     <= w_pdata;
         r_pidx      <= w_pidx;
         r_cmd_valid <= w_cmd_valid;
         r_pvalid    <= w_pvalid;
         r_done      <= w_done;
         r_err       <= w_err;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_len       = r_len;
      w_pcnt      = r_pcnt;
      w_cmd       = r_cmd;
      w_pdata     = r_pdata;
      w_pidx      = r_pidx;
      w_cmd_valid = 1'b0;
      w_pvalid    = 1'b0;
      w_done      = 1'b0;
      w_err       = 1'b0;

      // A byte arriving on the limit cycle takes priority over the timeout.
      if (rx_valid) begin
         if (rx_err) begin
            if (w_in_frame) begin
               w_err   = 1'b1;
               w_state = ST_IDLE;
            end
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (rx_data == SOF) w_state = ST_LEN;
               end
               ST_LEN: begin
                  w_len = rx_data;
                  if (rx_data < WORD_LENGTH'(2)) begin
                     w_err   = 1'b1;
                     w_state = ST_IDLE;
                  end else begin
                     w_pcnt  = '0;
                     w_pidx  = '0;
                     w_state = ST_CMD;
                  end
               end
               ST_CMD: begin
                  w_cmd       = rx_data;
                  w_cmd_valid = 1'b1;
                  w_state     = (r_len == WORD_LENGTH'(2)) ? ST_EOFCHK : ST_PAYLOAD;
               end
               ST_PAYLOAD: begin
                  w_pdata  = rx_data;
                  w_pidx   = r_pcnt;
                  w_pvalid = 1'b1;
                  w_pcnt   = r_pcnt + WORD_LENGTH'(1);
                  if (w_last_payload) w_state = ST_EOFCHK;
               end
               ST_EOFCHK: begin
                  w_done  = (rx_data == EOF);
                  w_err   = (rx_data != EOF);
                  w_state = ST_IDLE;
               end
               default: w_state = ST_IDLE;
            endcase
         end
      end else if (w_timeout && w_in_frame) begin
         w_err   = 1'b1;
         w_state = ST_IDLE;
      end
   end

   assign cmd           = r_cmd;
   assign cmd_valid     = r_cmd_valid;
   assign payload_data  = r_pdata;
   assign payload_valid = r_pvalid;
   assign payload_index = r_pidx;
   assign frame_done    = r_done;
   assign frame_err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
// ============================================================================
//  Module   : tb_uart_frame_parser
//  Brief    : Directed and randomized frames checked against an event model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_frame_parser;
   import p3_pkg::*;

   localparam int T = 40;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      int         kind;   // 0 cmd, 1 payload, 2 done, 3 err
      logic [7:0] data;
      logic [7:0] idx;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rx_err = 1'b0;
   logic [7:0] cmd, payload_data, payload_index;
   logic       cmd_valid, payload_valid, frame_done, frame_err;

   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;
   int  t_last_byte = 0;
   int  t_last_err = 0;
   ev_t expq[$];

   uart_frame_parser #(
      .WORD_LENGTH    (8),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_err        (rx_err),
      .cmd           (cmd),
      .cmd_valid     (cmd_valid),
      .payload_data  (payload_data),
      .payload_valid (payload_valid),
      .payload_index (payload_index),
      .frame_done    (frame_done),
      .frame_err     (frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_ev(input int k, input logic [7:0] d, input logic [7:0] i);
      ev_t e;
      e.kind = k; e.data = d; e.idx = i;
      expq.push_back(e);
   endtask

   task automatic take_ev(input int k, input logic [7:0] d, input logic [7:0] i);
      ev_t e;
      if (expq.size() == 0) begin
         check("unexpected_event", 32'(k), 32'hFFFF);
      end else begin
         e = expq.pop_front();
         check("event_kind", 32'(k), 32'(e.kind));
         if (k == e.kind && k <= 1) check("event_data", 32'(d), 32'(e.data));
         if (k == e.kind && k == 1) check("event_index", 32'(i), 32'(e.idx));
      end
   endtask

   // Output monitor: every pulse must match the next expected event
   always @(negedge clk) begin : mon
      int n;
      if (reset) begin
         n = int'(cmd_valid) + int'(payload_valid) + int'(frame_done) + int'(frame_err);
         if (n > 0) check("single_pulse", 32'(n), 32'd1);
         if (cmd_valid)     take_ev(0, cmd, 8'h00);
         if (payload_valid) take_ev(1, payload_data, payload_index);
         if (frame_done)    take_ev(2, 8'h00, 8'h00);
         if (frame_err) begin
            take_ev(3, 8'h00, 8'h00);
            t_last_err = cyc;
         end
      end
   end

   // Reference model: byte k of a frame (0 = SOF) is len, cmd, payload k-3, or EOF
   task automatic expect_frame(input bq_t fb, input int errpos);
      int len;
      len = int'(fb[1]);
      for (int i = 1; i < fb.size(); i++) begin
         if (i == errpos) begin push_ev(3, 8'h00, 8'h00); return; end
         if (i == 1) begin
            if (len < 2) begin push_ev(3, 8'h00, 8'h00); return; end
         end else if (i == 2) begin
            push_ev(0, fb[2], 8'h00);
         end else if (i <= len) begin
            push_ev(1, fb[i], 8'(i - 3));
         end else begin
            push_ev(fb[i] == EOF ? 2 : 3, 8'h00, 8'h00);
            return;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rx_valid = 1'b0;
         rx_err   = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic e, input int gap);
      idle(gap);
      @(negedge clk);
      rx_data     = b;
      rx_valid    = 1'b1;
      rx_err      = e;
      t_last_byte = cyc + 1;
   endtask

   task automatic run_frame(input string tag, input bq_t fb, input int errpos, input int maxgap);
      expect_frame(fb, errpos);
      for (int i = 0; i < fb.size(); i++) begin
         send_byte(fb[i], i == errpos, int'($urandom_range(0, maxgap)));
         if (i == errpos) break;
      end
      idle(3);
      check({tag, "_drained"}, 32'(expq.size()), 32'd0);
      expq.delete();
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_cmd"}, 32'(cmd), 32'd0);
      check({tag, "_pdata"}, 32'(payload_data), 32'd0);
      check({tag, "_pidx"}, 32'(payload_index), 32'd0);
      check({tag, "_pulses"}, {28'd0, cmd_valid, payload_valid, frame_done, frame_err}, 32'd0);
   endtask

   initial begin : stim
      bq_t fb;
      bq_t good;
      int  len, kind, errpos;
      good = '{8'hFE, 8'h02, 8'h03, 8'hEF};

      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      reset = 1'b1;
      idle(2);
      check_outputs_zero("post_reset");

      fb = '{8'hFE, 8'h03, 8'h01, 8'h03, 8'hEF};
      run_frame("one_payload", fb, -1, 0);
      run_frame("no_payload", good, -1, 2);
      fb = '{8'hFE, 8'h0B, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hEF};
      run_frame("nine_payload", fb, -1, 0);
      send_byte(8'h55, 1'b0, 0);
      fb = '{8'hFE, 8'h05, 8'h04, 8'hFE, 8'hEF, 8'h01, 8'hEF};
      run_frame("embedded_delims", fb, -1, 1);

      fb = '{8'hFE, 8'h02, 8'h03, 8'hAA};
      run_frame("bad_eof", fb, -1, 0);
      run_frame("after_bad_eof", good, -1, 0);
      fb = '{8'hFE, 8'h01};
      run_frame("short_len", fb, -1, 0);
      run_frame("after_short_len", good, -1, 0);
      fb = '{8'hFE, 8'h04, 8'h01, 8'hAA, 8'hBB, 8'hEF};
      run_frame("rx_err_mid", fb, 3, 1);
      run_frame("after_rx_err", good, -1, 0);

      // Counter reaches the limit after T idle clocks; the error lands one clock later
      fb = '{8'hFE, 8'h03, 8'h01};
      expect_frame(fb, -1);
      push_ev(3, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) send_byte(fb[i], 1'b0, 0);
      for (int k = 0; k < 3 * T && expq.size() > 0; k++) idle(1);
      check("timeout_seen", 32'(expq.size()), 32'd0);
      check("timeout_latency", 32'(t_last_err - t_last_byte), 32'(T + 1));
      expq.delete();
      run_frame("after_timeout", good, -1, 0);

      // A byte arriving exactly on the limit cycle keeps the frame alive
      fb = '{8'hFE, 8'h03, 8'h01, 8'h05, 8'hEF};
      expect_frame(fb, -1);
      for (int i = 0; i < 5; i++) send_byte(fb[i], 1'b0, (i == 3) ? T : 0);
      idle(3);
      check("limit_coincide_drained", 32'(expq.size()), 32'd0);
      expq.delete();

      // Reset mid-frame: no error pulse, outputs cleared immediately
      fb = '{8'hFE, 8'h0B, 8'h04, 8'h00};
      expect_frame(fb, -1);
      for (int i = 0; i < 4; i++) send_byte(fb[i], 1'b0, 0);
      idle(2);
      check("pre_reset_drained", 32'(expq.size()), 32'd0);
      expq.delete();
      #1 reset = 1'b0;
      #1 check_outputs_zero("mid_reset");
      idle(3);
      reset = 1'b1;
      idle(2);
      check_outputs_zero("after_mid_reset");
      run_frame("after_reset", good, -1, 0);

      for (int f = 0; f < 30; f++) begin
         if ($urandom_range(0, 3) == 0) begin
            logic [7:0] junk;
            junk = 8'($urandom_range(0, 255));
            if (junk == SOF) junk = 8'h00;
            send_byte(junk, 1'b0, 0);
            send_byte(SOF, 1'b1, 0);
         end
         kind = int'($urandom_range(0, 5));
         len  = int'($urandom_range(2, 12));
         if (kind == 5) len = int'($urandom_range(0, 1));
         fb = '{SOF, 8'(len)};
         if (len >= 2) begin
            for (int i = 0; i < len - 1; i++) fb.push_back(8'($urandom_range(0, 255)));
            fb.push_back((kind == 3) ? 8'($urandom_range(0, 8'hEE)) : EOF);
         end
         errpos = (kind == 4) ? int'($urandom_range(1, len + 1)) : -1;
         run_frame("random", fb, errpos, 3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
